// File: rtl/button_pulse_conditioner.sv
// Two-channel button front end: synchronises and debounces the raw increase /
// decrease buttons, then turns each debounced press into a single-cycle step
// pulse with optional auto-repeat while the button stays held.
// Channel index 0 is the up/increase button and index 1 is the down/decrease button.
module button_pulse_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_RATE     = 20000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_up_raw,
   input  logic btn_dn_raw,
   output logic inc_pulse,
   output logic dec_pulse,
   output logic up_level,
   output logic dn_level
);

   // REPEAT_DELAY >= REPEAT_RATE, so one repeat counter width covers both intervals.
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int RP_W = $clog2(REPEAT_DELAY);

   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

   // HELD is only reachable when auto-repeat is disabled.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2,
      HELD   = 2'd3
   } state_t;

   logic [1:0]      w_raw;
   logic [1:0]      r_s1;
   logic [1:0]      r_s2;
   logic [1:0]      r_level;
   logic [DB_W-1:0] r_db_cnt [2];
   state_t          r_state  [2];
   logic [RP_W-1:0] r_rp_cnt [2];
   logic [1:0]      w_req;
   logic            w_conflict;
   logic            r_inc;
   logic            r_dec;

   assign w_raw      = {btn_dn_raw, btn_up_raw};
   assign w_conflict = r_level[0] & r_level[1];

   // Two-flop synchroniser bringing the asynchronous buttons into the clk domain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         // NOTE: non-blocking assignments make r_s2 take the old r_s1, giving
         // two real flop stages; blocking here would collapse them into one.
         r_s1 <= w_raw;
         r_s2 <= r_s1;
      end
   end

   // Debouncer: the level follows s2 only after DEBOUNCE_CYCLES consecutive disagreeing edges.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_level <= '0;
         for (int ch = 0; ch < 2; ch++) r_db_cnt[ch] <= '0;
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            if (r_s2[ch] == r_level[ch]) begin
               r_db_cnt[ch] <= '0;
            end else if (r_db_cnt[ch] == DB_LAST) begin
               r_level[ch]  <= ~r_level[ch];
               r_db_cnt[ch] <= '0;
            end else begin
               r_db_cnt[ch] <= r_db_cnt[ch] + DB_W'(1);
            end
         end
      end
   end

   // Pulse request per channel, decoded from the current FSM state and repeat counter.
   always_comb begin
      // NOTE: the default assignment keeps w_req fully assigned on every path,
      // so no latch is inferred for the states that do not request.
      w_req = '0;
      for (int ch = 0; ch < 2; ch++) begin
         if (r_level[ch]) begin
            case (r_state[ch])
               IDLE:    w_req[ch] = 1'b1;
               DELAY:   w_req[ch] = (r_rp_cnt[ch] == DELAY_LAST);
               REPEAT:  w_req[ch] = (r_rp_cnt[ch] == RATE_LAST);
               default: w_req[ch] = 1'b0;
            endcase
         end
      end
   end

   // Press / auto-repeat FSM per channel; dropping the level always returns to IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int ch = 0; ch < 2; ch++) begin
            r_state[ch]  <= IDLE;
            r_rp_cnt[ch] <= '0;
         end
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            if (!r_level[ch]) begin
               r_state[ch]  <= IDLE;
               r_rp_cnt[ch] <= '0;
            end else begin
               case (r_state[ch])
                  IDLE: begin
                     r_rp_cnt[ch] <= '0;
                     r_state[ch]  <= (REPEAT_EN != 0) ? DELAY : HELD;
                  end
                  DELAY: begin
                     if (r_rp_cnt[ch] == DELAY_LAST) begin
                        r_rp_cnt[ch] <= '0;
                        r_state[ch]  <= REPEAT;
                     end else begin
                        r_rp_cnt[ch] <= r_rp_cnt[ch] + RP_W'(1);
                     end
                  end
                  REPEAT: begin
                     if (r_rp_cnt[ch] == RATE_LAST) r_rp_cnt[ch] <= '0;
                     else                           r_rp_cnt[ch] <= r_rp_cnt[ch] + RP_W'(1);
                  end
                  default: r_state[ch] <= HELD;
               endcase
            end
         end
      end
   end

   // Registered step pulses, masked while both buttons are debounced high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_inc <= 1'b0;
         r_dec <= 1'b0;
      end else begin
         r_inc <= w_req[0] & ~w_conflict;
         r_dec <= w_req[1] & ~w_conflict;
      end
   end

   assign inc_pulse = r_inc;
   assign dec_pulse = r_dec;
   assign up_level  = r_level[0];
   assign dn_level  = r_level[1];

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Self-checking bench for button_pulse_conditioner with shortened timing
// (debounce 4, repeat delay 20, repeat rate 8). A second instance with
// auto-repeat disabled shares the same inputs.
module tb_button_pulse_conditioner;

   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RR = 8;

   logic clk = 1'b0;
   logic rst_n, btn_up_raw, btn_dn_raw;
   logic inc_pulse, dec_pulse, up_level, dn_level;
   logic inc0, dec0, upl0, dnl0;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   int inc_q[$], dec_q[$], inc0_q[$], dec0_q[$];

   always #5 clk = ~clk;

   button_pulse_conditioner #(
      .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_up_raw(btn_up_raw), .btn_dn_raw(btn_dn_raw),
      .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .up_level(up_level), .dn_level(dn_level)
   );

   button_pulse_conditioner #(
      .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut_norep (
      .clk(clk), .rst_n(rst_n), .btn_up_raw(btn_up_raw), .btn_dn_raw(btn_dn_raw),
      .inc_pulse(inc0), .dec_pulse(dec0), .up_level(upl0), .dn_level(dnl0)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
   endtask

   function automatic string q2s(input int q[$]);
      string s = "";
      foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
      return s;
   endfunction

   task automatic check_q(input string name, input int got[$], input int exp[$]);
      bit ok = (got.size() == exp.size());
      if (ok) foreach (got[i]) if (got[i] != exp[i]) ok = 1'b0;
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got pulses at {%s } expected {%s }", name, q2s(got), q2s(exp));
   endtask

   // Edge counter and pulse loggers (each pulse tagged with the edge that produced it).
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (inc_pulse) inc_q.push_back(cyc);
      if (dec_pulse) dec_q.push_back(cyc);
      if (inc0)      inc0_q.push_back(cyc);
      if (dec0)      dec0_q.push_back(cyc);
   end

   // Reference model: the level flips once the last D synchronised samples all
   // disagree with it; pulses fall at hold offsets 0, RD, RD+RR, ... measured
   // from the first edge that sees the level high, masked when both levels are high.
   logic [31:0] m_raw_h [2];
   logic [31:0] m_s2_h  [2];
   int          m_k     [2];
   logic [1:0]  m_lvl  = '0;
   logic [1:0]  m_pls  = '0;
   logic [1:0]  m_pls0 = '0;

   always @(posedge clk) begin
      logic [1:0] pre, raw;
      logic       s2, req1, req0, both;
      raw = {btn_dn_raw, btn_up_raw};
      if (!rst_n) begin
         m_lvl  = '0;
         m_pls  = '0;
         m_pls0 = '0;
         for (int ch = 0; ch < 2; ch++) begin
            m_k[ch]     = -1;
            m_raw_h[ch] = '0;
            m_s2_h[ch]  = '0;
         end
      end else begin
         pre  = m_lvl;
         both = pre[0] & pre[1];
         for (int ch = 0; ch < 2; ch++) begin
            if (pre[ch]) m_k[ch] = (m_k[ch] < 0) ? 0 : m_k[ch] + 1;
            else         m_k[ch] = -1;
            req1 = pre[ch] && (m_k[ch] == 0 || (m_k[ch] >= RD && (m_k[ch] - RD) % RR == 0));
            req0 = pre[ch] && (m_k[ch] == 0);
            m_pls[ch]  = req1 && !both;
            m_pls0[ch] = req0 && !both;
            s2          = m_raw_h[ch][1];
            m_raw_h[ch] = {m_raw_h[ch][30:0], raw[ch]};
            m_s2_h[ch]  = {m_s2_h[ch][30:0], s2};
            if (m_s2_h[ch][D-1:0] == {D{~pre[ch]}}) m_lvl[ch] = ~pre[ch];
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en)
         check("model", {24'd0, inc_pulse, dec_pulse, up_level, dn_level, inc0, dec0, upl0, dnl0},
               {24'd0, m_pls[0], m_pls[1], m_lvl[0], m_lvl[1], m_pls0[0], m_pls0[1], m_lvl[0], m_lvl[1]});
   end

   typedef struct {
      logic       rst_n;
      logic       up;
      logic       dn;
      int         n;
      logic [3:0] exp;   // {inc_pulse, dec_pulse, up_level, dn_level}
   } vec_t;

   vec_t vecs [12];

   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic go_idle();
      rst_n = 1'b1; btn_up_raw = 1'b0; btn_dn_raw = 1'b0;
      wait_edges(20);
      inc_q.delete(); dec_q.delete(); inc0_q.delete(); dec0_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int f, start, len;
      int e[$], e0[$], none[$];

      rst_n = 1'b0; btn_up_raw = 1'b0; btn_dn_raw = 1'b0;

      vecs[0]  = '{1'b0, 1'b1, 1'b0,  5, 4'b0000};
      vecs[1]  = '{1'b1, 1'b1, 1'b0,  5, 4'b0000};
      vecs[2]  = '{1'b1, 1'b1, 1'b0,  1, 4'b0010};
      vecs[3]  = '{1'b1, 1'b1, 1'b0,  1, 4'b1010};
      vecs[4]  = '{1'b1, 1'b1, 1'b0,  1, 4'b0010};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 18, 4'b0010};
      vecs[6]  = '{1'b1, 1'b1, 1'b0,  1, 4'b1010};
      vecs[7]  = '{1'b1, 1'b1, 1'b0,  8, 4'b1010};
      vecs[8]  = '{1'b1, 1'b0, 1'b0,  5, 4'b0010};
      vecs[9]  = '{1'b1, 1'b0, 1'b0,  1, 4'b0000};
      vecs[10] = '{1'b1, 1'b0, 1'b1,  7, 4'b0101};
      vecs[11] = '{1'b1, 1'b0, 1'b0,  8, 4'b0000};

      @(negedge clk);
      mon_en = 1'b1;

      // Reset with button held, release, press pulse, first repeats, release, down press.
      for (int i = 0; i < 12; i++) begin
         rst_n = vecs[i].rst_n; btn_up_raw = vecs[i].up; btn_dn_raw = vecs[i].dn;
         wait_edges(vecs[i].n);
         check($sformatf("vec%0d", i), {28'd0, inc_pulse, dec_pulse, up_level, dn_level},
               {28'd0, vecs[i].exp});
      end

      // Bounce shorter than the debounce window, then one clean press.
      go_idle();
      btn_up_raw = 1'b1; wait_edges(3);
      btn_up_raw = 1'b0; wait_edges(1);
      btn_up_raw = 1'b1; wait_edges(3);
      btn_up_raw = 1'b0; wait_edges(4);
      check("bounce_level", {31'd0, up_level}, 32'd0);
      f = cyc + 1;
      btn_up_raw = 1'b1; wait_edges(10);
      btn_up_raw = 1'b0; wait_edges(25);
      e = {f + 6};
      check_q("bounce_inc", inc_q, e);

      // Auto-repeat while held, release timing, single pulse without repeat.
      go_idle();
      f = cyc + 1;
      btn_up_raw = 1'b1; wait_edges(60);
      btn_up_raw = 1'b0; wait_edges(5);
      check("release_hold", {31'd0, up_level}, 32'd1);
      wait_edges(1);
      check("release_fall", {31'd0, up_level}, 32'd0);
      wait_edges(15);
      e  = {f + 6, f + 26, f + 34, f + 42, f + 50, f + 58};
      e0 = {f + 6};
      check_q("repeat_inc", inc_q, e);
      check_q("norepeat_inc", inc0_q, e0);
      check_q("repeat_dec", dec_q, none);

      // Conflict: down pressed while up repeats; up resumes on its original grid.
      go_idle();
      f = cyc + 1;
      btn_up_raw = 1'b1; wait_edges(28);
      btn_dn_raw = 1'b1; wait_edges(12);
      btn_dn_raw = 1'b0; wait_edges(16);
      btn_up_raw = 1'b0; wait_edges(20);
      e = {f + 6, f + 26, f + 50, f + 58};
      check_q("conflict_inc", inc_q, e);
      check_q("conflict_dec", dec_q, none);
      check_q("conflict_dec_norep", dec0_q, none);

      // Reset in the middle of a repeat sequence with the button still held.
      go_idle();
      f = cyc + 1;
      btn_up_raw = 1'b1; wait_edges(35);
      rst_n = 1'b0; wait_edges(1);
      check("midreset_out", {28'd0, inc_pulse, dec_pulse, up_level, dn_level}, 32'd0);
      rst_n = 1'b1; wait_edges(28);
      btn_up_raw = 1'b0; wait_edges(20);
      e  = {f + 6, f + 26, f + 34, f + 42, f + 62};
      e0 = {f + 6, f + 42};
      check_q("midreset_inc", inc_q, e);
      check_q("midreset_inc_norep", inc0_q, e0);

      // Randomised bouncing presses, overlaps and occasional resets against the model.
      go_idle();
      start = cyc;
      while (cyc < start + 3000) begin
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0; wait_edges(1); rst_n = 1'b1;
         end
         btn_up_raw = 1'($urandom_range(0, 1));
         btn_dn_raw = ($urandom_range(0, 2) == 0);
         len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 70)) : int'($urandom_range(1, 6));
         wait_edges(len);
      end
      btn_up_raw = 1'b0; btn_dn_raw = 1'b0;
      wait_edges(20);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/button_pulse_conditioner.md
Name: button_pulse_conditioner

Overview:
- Two-channel button front end that sits directly upstream of the PWM duty-cycle generator.
- Turns the raw, asynchronous, bouncing increase and decrease buttons into clean single-cycle step pulses: one per press, plus auto-repeat while a button is held.
- Its `inc_pulse` and `dec_pulse` outputs drive the generator's duty-step inputs directly.
- Runs on the 100 MHz system clock.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised input must hold a new level before the debounced level changes (10 ms at 100 MHz); minimum 2.
- REPEAT_EN, 1: 1 enables auto-repeat while held; 0 gives exactly one pulse per press.
- REPEAT_DELAY, 50000000: cycles from the initial press pulse to the first repeat pulse (500 ms); must be at least REPEAT_RATE.
- REPEAT_RATE, 20000000: cycles between subsequent repeat pulses (200 ms); minimum 2.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- btn_up_raw  input  1  raw increase button, asynchronous, bouncing, active-high.
- btn_dn_raw  input  1  raw decrease button, asynchronous, bouncing, active-high.
- inc_pulse  output  1  registered one-cycle step-up pulse.
- dec_pulse  output  1  registered one-cycle step-down pulse.
- up_level  output  1  debounced level of the up button.
- dn_level  output  1  debounced level of the down button.

Behaviour:
- Reset: with rst_n low at a clk edge, all synchroniser flops, debounced levels, counters and FSMs clear to 0/IDLE. inc_pulse, dec_pulse, up_level and dn_level are 0.
- Reset mid-hold: an in-progress repeat sequence is aborted. A button still held after release of reset is treated as a new press.
- Both channels are identical and independent. Counter widths are derived with $clog2 from their parameters.
- Synchroniser: 2-flop, s1 <= raw, s2 <= s1.
- Debouncer:
  - Counter increments on every edge where s2 != level.
  - Counter clears on any edge where s2 == level, so a glitch shorter than DEBOUNCE_CYCLES resets it.
  - When s2 has differed from level on DEBOUNCE_CYCLES consecutive edges, level toggles and the counter clears.
  - Release is debounced identically.
- Latency: let edge 1 be the first edge that samples raw high, with raw held high. level rises at edge DEBOUNCE_CYCLES+2. The press pulse is high for the one cycle following edge DEBOUNCE_CYCLES+3.
- FSM per channel, with states IDLE, DELAY, REPEAT:
  - IDLE: on a level rising edge, request a pulse, clear the repeat counter, go to DELAY. If REPEAT_EN=0, go to a hold state (HELD) instead and wait for release.
  - DELAY: count. The pulse request fires exactly REPEAT_DELAY cycles after the initial pulse, then the FSM goes to REPEAT.
  - REPEAT: request a pulse every REPEAT_RATE cycles.
  - Any state: level low returns to IDLE the same edge with no pulse. Release never generates a pulse.
- Conflict rule: while up_level and dn_level are both 1, inc_pulse and dec_pulse are forced to 0.
  - FSMs and counters keep running during the conflict; only the pulses are masked.
  - When one button releases, the other channel resumes its current repeat schedule.
- Outputs are registered. Pulses are never longer than one cycle and never overlap.

Test Plan:
(Benches override DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.)
- Reset: btn_up_raw held high with rst_n low for 5 cycles -> all outputs 0. Keep button high and release rst_n -> up_level=1 after edge 6 and inc_pulse high for one cycle after edge 7, counted from rst_n release.
- Bounce: up raw high 3 cycles, low 1, high 3, low -> no inc_pulse, up_level stays 0. Then raw high for 10 cycles -> exactly one inc_pulse, 7 edges after the final rise.
- Auto-repeat: up raw held 60 cycles -> inc_pulse at T, T+20, T+28, T+36, T+44, and further pulses only while up_level=1.
- Release: drop raw -> up_level falls 6 edges later. No pulse at release, FSM returns to IDLE. With REPEAT_EN=0 and the same hold -> exactly one pulse.
- Conflict: up held in REPEAT, then dn pressed -> no inc_pulse or dec_pulse while both levels are 1. Release dn -> inc_pulse resumes on the original 8-cycle grid.
- Mid-hold reset: rst_n low for 1 cycle during REPEAT with raw still high -> outputs clear, then a fresh press pulse 7 edges after reset release, first repeat 20 cycles after that.
